store_buffer: RTL and testbench

Store buffer between the EX/MEM pipeline register and `Data_Memory` in the pipelined selection-sort processor. It queues retiring stores in a small FIFO and drains them to the single data-memory port on cycles when no load needs that port. Loads are served the same cycle, either from memory or by forwarding from a matching buffered store. It also provides an `empty` flag so the testbench can wait before sampling the memory `element*` outputs.

---
 rtl/mem_pkg.sv | 18 +
 rtl/sb_match.sv | 34 +++
 rtl/store_buffer.sv | 141 ++++++++++++++
 tb/tb_store_buffer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory side of the selection-sort pipeline.
package mem_pkg;

   localparam int unsigned SB_DEPTH       = 4;
   localparam int unsigned DW_OFFSET_BITS = 3;
   localparam int unsigned XLEN           = 64;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
   } sb_entry_t;

   // Two byte addresses refer to the same doubleword
   function automatic logic dw_match(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      return a[XLEN-1:DW_OFFSET_BITS] == b[XLEN-1:DW_OFFSET_BITS];
   endfunction

endpackage

// File: rtl/sb_match.sv
// Parallel address compare over the live store-buffer entries; the youngest
// matching entry (closest to tail) supplies hit_data.
module sb_match
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH,
   parameter int unsigned PTR_W = $clog2(DEPTH),
   parameter int unsigned CNT_W = PTR_W + 1
) (
   input  sb_entry_t        entries [DEPTH],
   input  logic [PTR_W-1:0] tail,
   input  logic [CNT_W-1:0] count,
   input  logic [XLEN-1:0]  addr,
   output logic             hit,
   output logic [XLEN-1:0]  hit_data
);

   logic [PTR_W-1:0] idx;

   // Walk from oldest live slot to youngest so the last match seen wins
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int k = int'(DEPTH); k >= 1; k--) begin
         idx = tail - PTR_W'(k);
         if ((CNT_W'(k) <= count) && dw_match(entries[idx].addr, addr)) begin
            hit      = 1'b1;
            hit_data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and Data_Memory: queues stores, drains them when the
// port is idle, serves loads same-cycle. Define STORE_FWD_EN to forward load hits.
module store_buffer
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            st_valid,
   input  logic            ld_valid,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            stall,
   output logic [XLEN-1:0] ld_data,
   output logic            empty,
   output logic [XLEN-1:0] mem_address,
   output logic [XLEN-1:0] mem_write_data,
   output logic            memorywrite,
   output logic            memoryread,
   input  logic [XLEN-1:0] mem_read_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   sb_entry_t        fifo [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic             empty_q;

   logic             is_st;
   logic             is_ld;
   logic             full;
   logic             hit;
   logic [XLEN-1:0]  hit_data;
   logic             accept;
   logic             drain;

   assign is_st = st_valid;
   assign is_ld = ld_valid & ~st_valid;
   assign full  = (count == CNT_W'(DEPTH));

   sb_match #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .CNT_W (CNT_W)
   ) u_match (
      .entries  (fifo),
      .tail     (tail),
      .count    (count),
      .addr     (addr),
      .hit      (hit),
      .hit_data (hit_data)
   );

`ifndef STORE_FWD_EN
   logic unused_hit_data;
   assign unused_hit_data = ^hit_data;
`endif

   // Port arbitration: a load miss owns the port, otherwise the head may drain
   always_comb begin
      stall          = 1'b0;
      accept         = 1'b0;
      drain          = 1'b0;
      ld_data        = '0;
      memoryread     = 1'b0;
      memorywrite    = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      if (!reset) begin
         if (is_st) begin
            // Full-stall ignores the same-cycle drain so it never depends on it
            stall  = full;
            accept = ~full;
            drain  = (count != '0);
         end else if (is_ld) begin
            if (hit) begin
`ifdef STORE_FWD_EN
               ld_data = hit_data;
               drain   = 1'b1;
`else
               stall   = 1'b1;
               drain   = 1'b1;
`endif
            end else begin
               memoryread  = 1'b1;
               mem_address = addr;
               ld_data     = mem_read_data;
            end
         end else begin
            drain = (count != '0);
         end
         if (drain) begin
            memorywrite    = 1'b1;
            mem_address    = fifo[head].addr;
            mem_write_data = fifo[head].data;
         end
      end
   end

   always_comb begin
      count_nxt = count;
      if (accept && !drain) begin
         count_nxt = count + CNT_W'(1);
      end else if (!accept && drain) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         empty_q <= 1'b1;
      end else begin
         if (accept) begin
            tail <= tail + PTR_W'(1);
         end
         if (drain) begin
            head <= head + PTR_W'(1);
         end
         count   <= count_nxt;
         empty_q <= (count_nxt == '0);
      end
   end

   // Entry storage needs no reset; liveness is tracked by head/count
   always_ff @(posedge clk) begin
      if (accept) begin
         fifo[tail] <= '{addr: addr, data: wdata};
      end
   end

   assign empty = empty_q | reset;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based model of pending stores
// and an architectural memory image; follows STORE_FWD_EN like the design.
module tb_store_buffer;
   import mem_pkg::*;

   localparam int unsigned MEM_WORDS = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic            st_valid;
   logic            ld_valid;
   logic [63:0]     addr;
   logic [63:0]     wdata;
   logic            stall;
   logic [63:0]     ld_data;
   logic            empty;
   logic [63:0]     mem_address;
   logic [63:0]     mem_write_data;
   logic            memorywrite;
   logic            memoryread;
   logic [63:0]     mem_read_data;

   logic [63:0]     mem     [MEM_WORDS];
   logic [63:0]     ref_mem [MEM_WORDS];
   sb_entry_t       q [$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .st_valid       (st_valid),
      .ld_valid       (ld_valid),
      .addr           (addr),
      .wdata          (wdata),
      .stall          (stall),
      .ld_data        (ld_data),
      .empty          (empty),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .memorywrite    (memorywrite),
      .memoryread     (memoryread),
      .mem_read_data  (mem_read_data)
   );

   // Data_Memory stand-in: combinational read, write on posedge
   assign mem_read_data = mem[mem_address[6:3]];
   always @(posedge clk) begin
      if (memorywrite) mem[mem_address[6:3]] <= mem_write_data;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: drive, predict from the model, compare, then advance the model
   task automatic step(input logic rst, input logic st, input logic ld,
                       input logic [63:0] a, input logic [63:0] d);
      logic        e_stall, e_rd, e_wr, drain, is_ld, hit;
      logic [63:0] e_addr, e_wd, e_ld, hd;
      @(negedge clk);
      reset = rst; st_valid = st; ld_valid = ld; addr = a; wdata = d;
      #1;
      e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0; drain = 1'b0;
      e_addr = '0; e_wd = '0; e_ld = '0; hit = 1'b0; hd = '0;
      is_ld = ld && !st;
      foreach (q[i]) begin
         if (q[i].addr[63:3] == a[63:3]) begin
            hit = 1'b1;
            hd  = q[i].data;
         end
      end
      if (rst) begin
         check_eq("rst_empty", 64'(empty), 64'd1);
      end else begin
         if (st) begin
            e_stall = (q.size() == 4);
            drain   = (q.size() > 0);
         end else if (is_ld) begin
            if (hit) begin
`ifdef STORE_FWD_EN
               e_ld = hd;
`else
               e_stall = 1'b1;
`endif
               drain = 1'b1;
            end else begin
               e_rd   = 1'b1;
               e_addr = a;
               e_ld   = ref_mem[a[6:3]];
            end
         end else begin
            drain = (q.size() > 0);
         end
         if (drain) begin
            e_wr   = 1'b1;
            e_addr = q[0].addr;
            e_wd   = q[0].data;
         end
         check_eq("empty", 64'(empty), 64'(q.size() == 0));
         if (is_ld && !e_stall) check_eq("ld_data", ld_data, e_ld);
      end
      check_eq("stall", 64'(stall), 64'(e_stall));
      check_eq("memoryread", 64'(memoryread), 64'(e_rd));
      check_eq("memorywrite", 64'(memorywrite), 64'(e_wr));
      check_eq("mem_address", mem_address, e_addr);
      check_eq("mem_write_data", mem_write_data, e_wd);
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else begin
         if (drain) begin
            ref_mem[q[0].addr[6:3]] = q[0].data;
            void'(q.pop_front());
         end
         if (st && !e_stall) q.push_back('{addr: a, data: d});
      end
   endtask

   initial begin
      logic [63:0] a, d;
      int unsigned r;
      mem[0] = 64'd15; mem[1] = 64'd2; mem[2] = 64'd1; mem[3] = 64'd44;
      for (int i = 4; i < int'(MEM_WORDS); i++) mem[i] = 64'(i * 7 + 3);
      for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = mem[i];
      reset = 1'b1; st_valid = 1'b0; ld_valid = 1'b0; addr = '0; wdata = '0;

      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 64'd16, 0);
      check_eq("load16", ld_data, 64'd1);
      // store-then-load forwarding / stall-and-drain
      step(0, 1, 0, 64'd8, 64'd99);
      step(0, 0, 1, 64'd8, 0);
      step(0, 0, 1, 64'd8, 0);
      check_eq("load8", ld_data, 64'd99);
      step(0, 0, 0, 0, 0);
      // two stores to one word under load misses
      step(0, 1, 0, 64'd0, 64'd5);
      step(0, 0, 1, 64'd32, 0);
      step(0, 1, 0, 64'd0, 64'd7);
      step(0, 0, 1, 64'd32, 0);
      step(0, 0, 1, 64'd0, 0);
      step(0, 0, 1, 64'd0, 0);
      check_eq("load0", ld_data, 64'd7);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check_eq("word0", mem[0], 64'd7);
      // pending store discarded by reset
      step(0, 1, 0, 64'd16, 64'd55);
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 64'd16, 0);
      check_eq("word2", mem[2], 64'd1);
      // random traffic, both-valid included
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         a = 64'($urandom_range(0, 7)) << 3;
         d = {$urandom(), $urandom()};
         if (r < 2)       step(1, 0, 0, a, d);
         else if (r < 40) step(0, 1, 0, a, d);
         else if (r < 45) step(0, 1, 1, a, d);
         else if (r < 85) step(0, 0, 1, a, d);
         else             step(0, 0, 0, a, d);
      end
      for (int n = 0; n < 6; n++) step(0, 0, 0, 0, 0);
      for (int i = 0; i < int'(MEM_WORDS); i++) check_eq("final_mem", mem[i], ref_mem[i]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
